if_fetch_ctrl: RTL

- Fetch-stage controller between the hazard/branch units and the ID stage.
- Computes the next word address fed back to the PC register and holds the IF/ID pipeline register.
- Latches a branch/jump redirect that arrives during a stall and applies it once the stall releases.
- Flushes wrong-path fetches.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/ifid_reg.sv | 56 +++++
 rtl/if_fetch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: address width, fetch FSM encoding,
// default NOP word and a word-address increment helper.
package cpu_pkg;

    localparam int ADDR_W = 30;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_PEND = 1'b1
    } fetch_state_e;

    // Next sequential word address; 30-bit modulo, so the top address wraps to 0.
    function automatic logic [ADDR_W-1:0] word_inc(input logic [ADDR_W-1:0] addr);
        word_inc = addr + 30'd1;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Hold freezes every field; flush replaces the
// fetched word with a bubble while still recording the fetch address.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [31:0]       inst_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] pc_plus1_in,
    output logic              id_valid,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus1
);

    logic              valid_r;
    logic [31:0]       inst_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_plus1_r;

    // Pipeline register update: reset, then hold, then flush, then normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= 1'b0;
            inst_r     <= NOP_INST;
            pc_r       <= 30'd0;
            pc_plus1_r <= 30'd0;
        end else if (hold) begin
            valid_r    <= valid_r;
            inst_r     <= inst_r;
            pc_r       <= pc_r;
            pc_plus1_r <= pc_plus1_r;
        end else if (flush) begin
            valid_r    <= 1'b0;
            inst_r     <= NOP_INST;
            pc_r       <= pc_in;
            pc_plus1_r <= pc_plus1_in;
        end else begin
            valid_r    <= 1'b1;
            inst_r     <= inst_in;
            pc_r       <= pc_in;
            pc_plus1_r <= pc_plus1_in;
        end
    end

    assign id_valid    = valid_r;
    assign id_inst     = inst_r;
    assign id_pc       = pc_r;
    assign id_pc_plus1 = pc_plus1_r;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: next-PC selection, parking of redirects that
// arrive while the pipe is stalled, and the IF/ID register.
// Build option IF_DELAY_SLOT_EN: when defined, the cycle that applies a
// redirect keeps the fetched word (delay-slot semantics) instead of
// flushing it; next-PC selection is the same either way.
module if_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic [31:0]       inst_in,
    output logic [ADDR_W-1:0] next_pc,
    output logic              id_valid,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus1,
    output logic              redirect_pending
);

    localparam logic [ADDR_W-1:0] RESET_WORD = RESET_ADDR[31:2];

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] pend_target_r;
    logic [ADDR_W-1:0] pend_target_nxt_s;
    logic [ADDR_W-1:0] pc_plus1_s;
    logic              apply_s;
    logic              flush_s;

    assign pc_plus1_s = word_inc(pc_cur);

    // A redirect takes effect on the first unstalled cycle that has one live or parked.
    assign apply_s = ~stall & (redirect_valid | (state_r == FS_PEND));

`ifdef IF_DELAY_SLOT_EN
    assign flush_s = 1'b0;
`else
    assign flush_s = apply_s;
`endif

    // Fetch FSM and parked-target register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FS_RUN;
            pend_target_r <= 30'd0;
        end else begin
            state_r       <= state_nxt_s;
            pend_target_r <= pend_target_nxt_s;
        end
    end

    // Next-state logic: park redirects seen under stall (latest wins), release on unstall.
    always_comb begin
        state_nxt_s       = state_r;
        pend_target_nxt_s = pend_target_r;
        case (state_r)
            FS_RUN: begin
                if (stall && redirect_valid) begin
                    state_nxt_s       = FS_PEND;
                    pend_target_nxt_s = redirect_target;
                end else begin
                    state_nxt_s       = FS_RUN;
                end
            end
            FS_PEND: begin
                if (stall) begin
                    if (redirect_valid) begin
                        pend_target_nxt_s = redirect_target;
                    end else begin
                        pend_target_nxt_s = pend_target_r;
                    end
                end else begin
                    // Parked (or overriding live) redirect is issued this cycle.
                    state_nxt_s       = FS_RUN;
                    pend_target_nxt_s = 30'd0;
                end
            end
            default: begin
                state_nxt_s       = FS_RUN;
                pend_target_nxt_s = 30'd0;
            end
        endcase
    end

    // Next-PC mux: reset, hold, live redirect, parked redirect, sequential.
    always_comb begin
        next_pc = pc_plus1_s;
        if (rst) begin
            next_pc = RESET_WORD;
        end else if (stall) begin
            next_pc = pc_cur;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (state_r == FS_PEND) begin
            next_pc = pend_target_r;
        end else begin
            next_pc = pc_plus1_s;
        end
    end

    assign redirect_pending = (state_r == FS_PEND);

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .hold        (stall),
        .flush       (flush_s),
        .inst_in     (inst_in),
        .pc_in       (pc_cur),
        .pc_plus1_in (pc_plus1_s),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1)
    );

endmodule
